// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// RV32I load/store funct3 codes, FSM state encoding and the
// funct3/alignment legality check.
package dmem_responder_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // True when funct3 is illegal for the direction or the address is
  // misaligned for the access size. Range checking needs the storage
  // depth and is done by the caller.
  function automatic logic access_fault(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b1;
    if (write) begin
      case (funct3)
        F3_SB:   fault = 1'b0;
        F3_SH:   fault = addr_lo[0];
        F3_SW:   fault = (addr_lo != 2'b00);
        default: fault = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: fault = 1'b0;
        F3_LH, F3_LHU: fault = addr_lo[0];
        F3_LW:         fault = (addr_lo != 2'b00);
        default:       fault = 1'b1;
      endcase
    end
    return fault;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU load/store path (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_load_extend.sv
// Selects the addressed byte/half/word of a storage word and sign- or
// zero-extends it according to the load funct3.
module dmem_load_extend
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection and extension, little-endian lanes
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path through the case can leave it unassigned (latch).
    data     = '0;
    sel_byte = word[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  data = {24'h0, sel_byte};
      F3_LH:   data = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  data = {16'h0, sel_half};
      F3_LW:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time,
// inserts WAIT_CYCLES wait states, performs the byte/half/word access
// and returns extended load data or an error on the response channel.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;

  // Request fields captured at the accept edge
  logic                lat_write;
  logic                lat_err;
  logic [2:0]          lat_funct3;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;

  logic [ADDR_W-3:0]   req_word;
  logic [ADDR_W-3:0]   lat_word;
  logic                req_err;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_lanes;
  logic [31:0]         mem_word;
  logic [31:0]         load_data;

  logic [31:0]         mem [DEPTH_WORDS];

  assign req_word = bus.req_addr[ADDR_W-1:2];
  assign lat_word = lat_addr[ADDR_W-1:2];
  assign req_err  = access_fault(bus.req_write, bus.req_funct3, bus.req_addr[1:0])
                 || (32'(req_word) >= 32'(DEPTH_WORDS));
  assign mem_word = mem[lat_word[IDX_W-1:0]];

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  dmem_load_extend u_load_extend (
    .word    (mem_word),
    .funct3  (lat_funct3),
    .addr_lo (lat_addr[1:0]),
    .data    (load_data)
  );

  // Store byte enables and lane-replicated store data
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = lat_wdata;
    case (lat_funct3)
      F3_SB: begin
        byte_en     = 4'b0001 << lat_addr[1:0];
        wdata_lanes = {4{lat_wdata[7:0]}};
      end
      F3_SH: begin
        byte_en     = lat_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{lat_wdata[15:0]}};
      end
      F3_SW:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Storage write port: commits on the edge leaving ACCESS, never while
  // reset is asserted, so an interrupted store leaves storage untouched
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; it must map onto RAM and
    // keep its contents across a responder reset.
    if (!rst && state == S_ACCESS && lat_write && !lat_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[lat_word[IDX_W-1:0]][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  // Errored requests skip WAIT but still spend the single ACCESS cycle
  // (with the commit suppressed), so the error response appears one
  // edge after acceptance.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            lat_write   <= bus.req_write;
            lat_funct3  <= bus.req_funct3;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            lat_err     <= req_err;
            req_ready_q <= 1'b0;
            if (req_err || WAIT_CYCLES == 0) begin
              state <= S_ACCESS;
            end else begin
              wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
              state    <= S_WAIT;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= lat_err;
          rsp_rdata_q <= (lat_err || lat_write) ? 32'h0 : load_data;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, back-pressure and
// reset-during-wait sequences, then randomized traffic against a
// byte-array reference model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int DEPTH_WORDS = 48;
  localparam int WAIT_CYCLES = 2;
  localparam int GOOD_LAT    = WAIT_CYCLES + 1;
  localparam int ERR_LAT     = 1;
  localparam int NVEC        = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus();

  dmem_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [NVEC];

  // Reference storage, byte addressed
  logic [7:0] mb [DEPTH_WORDS*4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference behaviour derived from access size, alignment and range
  task automatic model_access(input logic w, input logic [2:0] f3, input logic [7:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int a, size;
    logic legal, sgn;
    logic [31:0] v;
    a = int'(addr);
    if (w) begin
      legal = (f3 <= 3'd2);
      sgn   = 1'b0;
    end else begin
      legal = (f3 != 3'd3) && (f3 < 3'd6);
      sgn   = (f3 < 3'd4);
    end
    size = 1 << f3[1:0];
    e  = !legal || (a % size != 0) || (a / 4 >= DEPTH_WORDS);
    rd = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < size; i++) mb[a+i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mb[a+i]) << (8*i));
        if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        rd = v;
      end
    end
  endtask

  // One complete transaction; lat counts edges from accept to rsp_valid
  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output logic ok);
    int n;
    ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
    @(negedge clk);
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      timeout("accept");
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.rsp_valid) break;
    end
    if (!bus.rsp_valid) begin
      timeout("response");
      return;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, held;
    logic        er, exp_er, ok, w;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          lat, n, a, sz;

    vecs[0]  = '{1'b1, F3_SW,  8'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, F3_LW,  8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, F3_LB,  8'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{1'b0, F3_LBU, 8'h13, 32'h0,        32'h000000DE, 1'b0};
    vecs[4]  = '{1'b0, F3_LH,  8'h10, 32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{1'b0, F3_LHU, 8'h12, 32'h0,        32'h0000DEAD, 1'b0};
    vecs[6]  = '{1'b1, F3_SB,  8'h11, 32'h000000AA, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, F3_LW,  8'h10, 32'h0,        32'hDEADAAEF, 1'b0};
    vecs[8]  = '{1'b0, F3_LW,  8'h12, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b1, F3_SH,  8'h11, 32'h0000FFFF, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 3'b011, 8'h10, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, F3_LW,  8'h10, 32'h0,        32'hDEADAAEF, 1'b0};
    vecs[12] = '{1'b1, F3_SW,  8'hC0, 32'h11111111, 32'h0,        1'b1};
    vecs[13] = '{1'b0, F3_LW,  8'hFC, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 3'b100, 8'h10, 32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b1, F3_SW,  8'hBC, 32'h80112233, 32'h0,        1'b0};
    vecs[16] = '{1'b0, F3_LB,  8'hBF, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[17] = '{1'b0, F3_LHU, 8'hBE, 32'h0,        32'h00008011, 1'b0};
    vecs[18] = '{1'b1, F3_SH,  8'h12, 32'h12345678, 32'h0,        1'b0};
    vecs[19] = '{1'b0, F3_LW,  8'h10, 32'h0,        32'h5678AAEF, 1'b0};
    vecs[20] = '{1'b0, F3_LH,  8'h11, 32'h0,        32'h0,        1'b1};
    vecs[21] = '{1'b1, F3_SW,  8'h20, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[22] = '{1'b0, F3_LB,  8'hBC, 32'h0,        32'h00000033, 1'b0};
    vecs[23] = '{1'b0, F3_LW,  8'h20, 32'h0,        32'hCAFEF00D, 1'b0};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    rst            = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'h0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset rsp_err",   32'(bus.rsp_err),   32'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d rdata", i), rd, vecs[i].rdata);
        check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].err));
        check($sformatf("vec%0d latency", i), 32'(lat), vecs[i].err ? 32'(ERR_LAT) : 32'(GOOD_LAT));
      end
    end

    // Back-pressure: response held, second request must not be accepted
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_funct3 = F3_LW; bus.req_addr = 8'h10; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) timeout("bp accept");
    @(posedge clk);
    #1;
    bus.req_write = 1'b1; bus.req_funct3 = F3_SW; bus.req_wdata = 32'h0;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
    if (!bus.rsp_valid) timeout("bp response");
    held = bus.rsp_rdata;
    check("bp first rdata", held, 32'h5678AAEF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d rsp_valid", c), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("bp hold%0d rsp_rdata", c), bus.rsp_rdata, 32'h5678AAEF);
      check($sformatf("bp hold%0d req_ready", c), 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp handshake done", 32'(bus.rsp_valid), 32'h0);
    run_txn(1'b0, F3_LW, 8'h10, 32'h0, rd, er, lat, ok);
    if (ok) check("bp no second store", rd, 32'h5678AAEF);

    // Reset while the store sits in WAIT: no commit
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_funct3 = F3_SW; bus.req_addr = 8'h20;
    bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) timeout("rst accept");
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst mid req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    check("rst idle req_ready", 32'(bus.req_ready), 32'h1);
    run_txn(1'b0, F3_LW, 8'h20, 32'h0, rd, er, lat, ok);
    if (ok) check("rst store dropped", rd, 32'hCAFEF00D);

    // Randomized traffic: fill all storage first, then mixed accesses
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      wd = $urandom;
      model_access(1'b1, F3_SW, 8'(i*4), wd, exp_rd, exp_er);
      run_txn(1'b1, F3_SW, 8'(i*4), wd, rd, er, lat, ok);
      if (ok) check($sformatf("fill%0d err", i), 32'(er), 32'(exp_er));
    end
    for (int i = 0; i < 300; i++) begin
      w    = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = int'($urandom_range(0, 255));
      sz   = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      addr = 8'(a);
      wd   = $urandom;
      model_access(w, f3, addr, wd, exp_rd, exp_er);
      run_txn(w, f3, addr, wd, rd, er, lat, ok);
      if (ok) begin
        check($sformatf("rand%0d rdata", i), rd, exp_rd);
        check($sformatf("rand%0d err", i), 32'(er), 32'(exp_er));
        check($sformatf("rand%0d latency", i), 32'(lat), exp_er ? 32'(ERR_LAT) : 32'(GOOD_LAT));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
